// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal baud divider, a small write FIFO and
// configurable data width, parity mode and stop-bit count. TxOut idles high.
module uart_tx_fifo #(
  parameter int CLK_DIV   = 1302,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              WrEn,
  input  logic [DATA_W-1:0] WrData,
  output logic              Full,
  output logic              Empty,
  output logic              Overflow,
  output logic              Busy,
  output logic              TxOut
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = 4;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_W - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_n;
  logic              push, pop;

  // Full is the registered flag, so a write is dropped even if a pop lands in the same cycle.
  assign push    = WrEn && !Full;
  assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= WrData;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      Full     <= 1'b0;
      Empty    <= 1'b1;
      Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      Full  <= (count_n == FULL_CNT);
      Empty <= (count_n == '0);
      if (WrEn && Full) Overflow <= 1'b1;
    end
  end

  state_t            state, state_n;
  logic [CW-1:0]     baud, baud_n;
  logic [IW-1:0]     idx, idx_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              par_bit, par_n, tx_n, bit_end;

  assign bit_end = (baud == BAUD_LAST);
  assign Busy    = (state != ST_IDLE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_IDLE;
      baud    <= '0;
      idx     <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      TxOut   <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      idx     <= idx_n;
      shift   <= shift_n;
      par_bit <= par_n;
      TxOut   <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = '0;
    idx_n   = idx;
    shift_n = shift;
    par_n   = par_bit;
    pop     = 1'b0;
    tx_n    = 1'b1;
    if (state != ST_IDLE && !bit_end) baud_n = baud + 1'b1;
    case (state)
      ST_IDLE:  pop = !Empty;
      ST_START: if (bit_end) begin
        state_n = ST_DATA;
        idx_n   = '0;
      end
      ST_DATA: if (bit_end) begin
        shift_n = shift >> 1;
        idx_n   = idx + 1'b1;
        if (idx == DATA_LAST) begin
          state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
          idx_n   = '0;
        end
      end
      ST_PARITY: if (bit_end) state_n = ST_STOP;
      ST_STOP: if (bit_end) begin
        idx_n = idx + 1'b1;
        if (idx == STOP_LAST) begin
          idx_n   = '0;
          pop     = !Empty;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Popping from IDLE or the last stop bit goes straight into a start bit.
    if (pop) begin
      state_n = ST_START;
      shift_n = mem[rd_ptr];
      par_n   = (PARITY == 1) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
    end
    // TxOut is registered, so drive the level of the state being entered.
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_n[0];
      ST_PARITY: tx_n = par_n;
      default:   tx_n = 1'b1;
    endcase
  end
endmodule
